soc_system_pesos_stream: RTL and testbench

SOC_SYSTEM_PESOS_STREAM -- requirements
Module: soc_system_pesos_stream

---
 rtl/soc_system_pesos_stream.sv | 119 +++++++++++
 tb/tb_soc_system_pesos_stream.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pesos_stream.sv
// soc_system_pesos_stream: dual-port word RAM with Avalon-MM slave and skid-buffered stream reader; define SOC_PESOS_FREEZE_EN to let freeze block writes and stream starts
module soc_system_pesos_stream #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 6,
  parameter string INIT_FILE = "kdata.hex"
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  input  logic                freeze,
  input  logic                st_start,
  input  logic [ADDR_W-1:0]   st_base,
  input  logic [ADDR_W:0]     st_count,
  output logic                st_valid,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_last,
  input  logic                st_ready,
  output logic                st_busy,
  output logic                st_done
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int BE_W  = DATA_W/8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_b;
  logic [ADDR_W:0]   rem;
  logic [DATA_W-1:0] fd [2];
  logic [1:0]        fl;
  logic              wp, rp;
  logic [1:0]        cnt;
  logic              frz, start_ok, issue, pop, done_d, last_issue, rd_a;

`ifdef SOC_PESOS_FREEZE_EN
  assign frz = freeze;
`else
  logic unused_freeze;
  assign unused_freeze = freeze;
  assign frz = 1'b0;
`endif

  assign rd_a       = chipselect && read && !write;
  assign start_ok   = st_start && state == IDLE && !frz;
  assign last_issue = rem == {{ADDR_W{1'b0}}, 1'b1};
  assign st_valid   = cnt != 2'd0;
  assign st_data    = fd[rp];
  assign st_last    = st_valid && fl[rp];
  assign st_busy    = state != IDLE;
  assign pop        = st_valid && st_ready;

  // Reads land straight in the skid buffer, so issuing only needs a free slot
  always_comb begin
    issue   = state == RUN && cnt != 2'd2;
    done_d  = (start_ok && st_count == '0) || (state == DRAIN && pop && st_last);
    state_d = (start_ok && st_count != '0) ? RUN :
              (issue && last_issue)        ? DRAIN :
              (state == DRAIN && pop && st_last) ? IDLE : state;
  end

  always_ff @(posedge clk) begin
    if (chipselect && write && !frz)
      for (int i = 0; i < BE_W; i++)
        if (byteenable[i]) mem[address][8*i +: 8] <= writedata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_a;
      if (rd_a) readdata <= mem[address];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      st_done <= 1'b0;
      addr_b  <= '0;
      rem     <= '0;
    end else begin
      state   <= state_d;
      st_done <= done_d;
      if (start_ok) begin
        addr_b <= st_base;
        rem    <= st_count;
      end else if (issue) begin
        addr_b <= addr_b + ADDR_W'(1);
        rem    <= rem - {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fd  <= '{default: '0};
      fl  <= '0;
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= '0;
    end else begin
      if (issue) begin
        fd[wp] <= mem[addr_b];
        fl[wp] <= last_issue;
        wp     <= !wp;
      end
      if (pop) rp <= !rp;
      cnt <= cnt + {1'b0, issue} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_soc_system_pesos_stream.sv
// tb_soc_system_pesos_stream: directed stimulus with queue scoreboard for Avalon reads and stream beats
module tb_soc_system_pesos_stream;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [5:0]  address = '0, st_base = '0;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0, freeze = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0, readdata, st_data;
  logic        readdatavalid, st_start = 1'b0, st_valid, st_last, st_ready = 1'b0, st_busy, st_done;
  logic [6:0]  st_count = '0;

  int          checks = 0, errors = 0, beats = 0, beats0;
  logic [31:0] model [64];
  logic [31:0] rq [$];
  logic [32:0] sq [$];
  logic [31:0] exp_r;
  logic [32:0] exp_s, stall_v;
  logic        stall_q = 1'b0, seen;

  always #5 clk = ~clk;

  soc_system_pesos_stream #(.DATA_W(32), .ADDR_W(6), .INIT_FILE("")) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .byteenable(byteenable), .writedata(writedata),
    .readdata(readdata), .readdatavalid(readdatavalid), .freeze(freeze),
    .st_start(st_start), .st_base(st_base), .st_count(st_count), .st_valid(st_valid),
    .st_data(st_data), .st_last(st_last), .st_ready(st_ready), .st_busy(st_busy),
    .st_done(st_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents data
  always @(negedge clk) begin
    if (reset_n && stall_q) chk("st_hold", {st_valid, st_last, st_data}, {1'b1, stall_v});
    if (readdatavalid) begin
      if (rq.size() == 0) chk("rdv_unexpected", 1, 0);
      else begin
        exp_r = rq.pop_front();
        chk("readdata", readdata, exp_r);
      end
    end
    if (st_valid && st_ready) begin
      beats++;
      if (sq.size() == 0) chk("beat_unexpected", 1, 0);
      else begin
        exp_s = sq.pop_front();
        chk("st_beat", {st_last, st_data}, exp_s);
      end
    end
    stall_q = reset_n && st_valid && !st_ready;
    stall_v = {st_last, st_data};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic av_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
    tick();
    chipselect = 1'b0; write = 1'b0;
    for (int i = 0; i < 4; i++) if (be[i]) model[a][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic av_rd(input logic [5:0] a, input logic [31:0] e);
    rq.push_back(e);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic start(input logic [5:0] b, input logic [6:0] c);
    st_base = b; st_count = c; st_start = 1'b1;
    tick();
    st_start = 1'b0;
  endtask

  task automatic push_stream(input logic [5:0] b, input int c);
    for (int i = 0; i < c; i++) begin
      logic [5:0] a;
      a = b + 6'(i);
      sq.push_back({i == c - 1, model[a]});
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = st_done;
    end
    chk(name, seen, 1);
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    chk("rst_stream", {st_valid, st_last, st_busy, st_done}, 0);
    chk("rst_avalon", {readdatavalid, readdata}, 0);
    chk("rst_st_data", st_data, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 64; i++) av_wr(6'(i), {8'hC0, 8'(i), ~8'(i), 8'(i * 3)}, 4'hF);
    av_rd(5, 32'hC005FA0F);
    av_wr(3, 32'h11223344, 4'hF);
    av_wr(3, 32'hAABBCCDD, 4'b0101);
    av_rd(3, 32'h11BB33DD);

    // zero-length request: no busy, done next cycle
    start(0, 0);
    @(negedge clk);
    chk("cnt0_done", {st_done, st_busy}, 2'b10);
    tick();

    // wrap-around stream, with a start pulse while busy that must be ignored
    st_ready = 1'b1;
    push_stream(62, 4);
    start(62, 4);
    @(negedge clk);
    chk("lat_early", {st_valid, st_busy}, 2'b01);
    tick();
    for (int k = 0; k < 4; k++) begin
      st_start = k == 1; st_base = 6'd0; st_count = 7'd2;
      @(negedge clk);
      chk("no_bubble", st_valid, 1);
      tick();
    end
    st_start = 1'b0;
    @(negedge clk);
    chk("wrap_done", {st_done, st_busy, st_valid}, 3'b100);
    tick();

    // backpressure with ready pattern 1,0,0,1
    push_stream(0, 8);
    start(0, 8);
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      st_ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
      seen = st_done;
      tick();
    end
    chk("toggle_done", seen, 1);
    st_ready = 1'b1;

    // same-cycle port-A write and port-B read deliver old data
    sq.push_back({1'b1, model[10]});
    st_base = 6'd10; st_count = 7'd1; st_start = 1'b1;
    tick();
    st_start = 1'b0;
    av_wr(10, 32'hDEADBEEF, 4'hF);
    wait_done(10, "coll_done");
    av_rd(10, 32'hDEADBEEF);

    // reset after three beats
    push_stream(20, 10);
    beats0 = beats;
    start(20, 10);
    repeat (4) tick();
    st_ready = 1'b0;
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_out", {st_valid, st_last, st_busy, st_done, readdatavalid, readdata, st_data}, 0);
    chk("midrst_beats", beats - beats0, 3);
    sq.delete();
    tick();
    reset_n = 1'b1;
    st_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | st_done | st_busy;
      tick();
    end
    chk("midrst_nodone", seen, 0);
    av_rd(20, model[20]);
    av_rd(22, model[22]);
    av_rd(29, model[29]);

`ifdef SOC_PESOS_FREEZE_EN
    freeze = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 6'd7; writedata = '0; byteenable = 4'hF;
    tick();
    chipselect = 1'b0; write = 1'b0;
    start(7, 3);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | st_busy | st_valid;
      tick();
    end
    chk("frz_nobusy", seen, 0);
    av_rd(7, 32'hC007F815);
    freeze = 1'b0;
`else
    freeze = 1'b1;
    av_wr(7, 32'h0, 4'hF);
    push_stream(7, 3);
    start(7, 3);
    wait_done(20, "nofrz_done");
    av_rd(7, 32'h0);
    freeze = 1'b0;
`endif

    repeat (3) tick();
    chk("rq_empty", rq.size(), 0);
    chk("sq_empty", sq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
